// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, issues req/gnt/rvalid fetches, buffers
// returned words in a 2-entry FIFO and drives if22id_bus; redirects drop stale responses.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int          IF22ID_WD = 65,
  parameter int          STALL_WD  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [31:0]          flush_pc,
  input  logic [32:0]          br_bus,
  input  logic [STALL_WD-1:0]  stall,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output logic [IF22ID_WD-1:0] if22id_bus
);

  logic        br_e, hold, redirect, issue, push, pop, kill_rsp;
  logic [31:0] br_addr, target;
  logic [2:0]  occupancy;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  kill_q, kill_d;
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;
  logic        tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic        fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
  logic [31:0] tag_q       [2];
  logic [31:0] fifo_inst_q [2];
  logic [31:0] fifo_pc_q   [2];
  logic        unused_stall;

  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign hold         = stall[1];
  assign unused_stall = ^{stall[STALL_WD-1:2], stall[0]};

  // A branch is only taken when decode accepts this cycle; flush always wins.
  assign redirect  = flush | (br_e & ~hold);
  assign target    = flush ? flush_pc : br_addr;
  assign occupancy = {1'b0, fifo_cnt_q} + {1'b0, out_q};

  assign imem_req  = ~rst & ~redirect & (occupancy < 3'd2);
  assign imem_addr = pc_q;
  assign issue     = imem_req & imem_gnt;
  assign kill_rsp  = imem_rvalid & (kill_q != 2'd0);
  assign push      = imem_rvalid & (kill_q == 2'd0) & ~redirect;
  assign pop       = (fifo_cnt_q != 2'd0) & ~hold & ~redirect;

  assign if22id_bus = (fifo_cnt_q != 2'd0)
                    ? {fifo_inst_q[fifo_rp_q], 1'b1, fifo_pc_q[fifo_rp_q]}
                    : '0;

  always_comb begin
    pc_d       = pc_q;
    out_d      = out_q + {1'b0, issue} - {1'b0, imem_rvalid};
    kill_d     = kill_q;
    tag_wp_d   = tag_wp_q;
    tag_rp_d   = tag_rp_q;
    fifo_wp_d  = fifo_wp_q;
    fifo_rp_d  = fifo_rp_q;
    fifo_cnt_d = fifo_cnt_q;

    if (redirect)   pc_d = target;
    else if (issue) pc_d = pc_q + 32'd4;

    if (issue)       tag_wp_d = ~tag_wp_q;
    if (imem_rvalid) tag_rp_d = ~tag_rp_q;

    // Every request still in flight after this cycle belongs to the old path.
    if (redirect)      kill_d = out_q - {1'b0, imem_rvalid};
    else if (kill_rsp) kill_d = kill_q - 2'd1;

    if (redirect) begin
      fifo_wp_d  = 1'b0;
      fifo_rp_d  = 1'b0;
      fifo_cnt_d = 2'd0;
    end else begin
      if (push) fifo_wp_d = ~fifo_wp_q;
      if (pop)  fifo_rp_d = ~fifo_rp_q;
      fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      out_q      <= 2'd0;
      kill_q     <= 2'd0;
      tag_wp_q   <= 1'b0;
      tag_rp_q   <= 1'b0;
      fifo_wp_q  <= 1'b0;
      fifo_rp_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      pc_q       <= pc_d;
      out_q      <= out_d;
      kill_q     <= kill_d;
      tag_wp_q   <= tag_wp_d;
      tag_rp_q   <= tag_rp_d;
      fifo_wp_q  <= fifo_wp_d;
      fifo_rp_q  <= fifo_rp_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Payload storage needs no reset; validity comes from the pointers and counts.
  always_ff @(posedge clk) begin
    if (issue) tag_q[tag_wp_q] <= pc_q;
    if (push) begin
      fifo_inst_q[fifo_wp_q] <= imem_rdata;
      fifo_pc_q[fifo_wp_q]   <= tag_q[tag_rp_q];
    end
  end

  a_rvalid_has_outstanding: assert property (
    @(posedge clk) disable iff (rst) imem_rvalid |-> (out_q != 2'd0));

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a memory model answers fetches, stimulus queues
// expected fetch addresses and decode-bus words, a monitor pops and compares them.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic [32:0] br_bus;
  logic [5:0]  stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [64:0] if22id_bus;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pendT;

  pendT        pend[$];
  logic [31:0] expAddr[$];
  logic [64:0] expBus[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cycleCnt = 0;
  int          grantLimit = 0;
  int          granted = 0;
  int          lat = 1;
  logic        redirectNow;

  if_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .br_bus     (br_bus),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if22id_bus (if22id_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic logic [31:0] instOf(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [64:0] busOf(input logic [31:0] a);
    return {instOf(a), 1'b1, a};
  endfunction

  task automatic checkOutput(input string name, input logic [64:0] actual,
                             input logic [64:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic pushPcs(input logic [31:0] base, input int n, input bit toBus);
    for (int i = 0; i < n; i++) begin
      expAddr.push_back(base + 32'(4 * i));
      if (toBus) expBus.push_back(busOf(base + 32'(4 * i)));
    end
    grantLimit += n;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((expAddr.size() != 0 || expBus.size() != 0) && n < 100) begin
      stepCycle();
      n++;
    end
    compared++;
    if (n >= 100) begin
      mismatched++;
      $display("[TB] FAIL %s drain: got %0d/%0d entries left expected 0/0",
               name, expAddr.size(), expBus.size());
    end
    repeat (3) stepCycle();
  endtask

  // Memory: grants up to grantLimit requests, answers in order after lat cycles.
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      if (pend.size() != 0 && pend[0].due <= cycleCnt) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instOf(pend[0].addr);
        void'(pend.pop_front());
      end
      imem_gnt = 1'b0;
      if (imem_req && granted < grantLimit) begin
        pendT p;
        p.addr = imem_addr;
        p.due  = cycleCnt + lat;
        pend.push_back(p);
        imem_gnt = 1'b1;
        granted++;
      end
    end
  end

  // Monitor: a grant consumes one expected address, an accepted bus word one expected word.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (imem_req && imem_gnt) begin
        if (expAddr.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL grant addr: got %h expected no request", imem_addr);
        end else checkOutput("grant addr", {33'd0, imem_addr}, {33'd0, expAddr.pop_front()});
      end
      redirectNow = flush | (br_bus[32] & ~stall[1]);
      if (if22id_bus[32] && !stall[1] && !redirectNow) begin
        if (expBus.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL bus word: got %h expected no output", if22id_bus);
        end else checkOutput("bus word", if22id_bus, expBus.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus;
    rst = 1'b1; flush = 1'b0; flush_pc = 32'd0; br_bus = 33'd0; stall = 6'd0;
    repeat (3) stepCycle();
    #7;
    checkOutput("reset req", {64'd0, imem_req}, 65'd0);
    checkOutput("reset bus", if22id_bus, 65'd0);

    // Streaming after reset with single-cycle memory.
    stepCycle();
    rst = 1'b0;
    pushPcs(RST_PC, 8, 1'b1);
    #7;
    checkOutput("first addr", {33'd0, imem_addr}, {33'd0, RST_PC});
    checkOutput("bus empty c0", if22id_bus, 65'd0);
    stepCycle(); #7;
    checkOutput("bus empty c1", if22id_bus, 65'd0);
    stepCycle(); #7;
    checkOutput("bus valid c2", if22id_bus, busOf(RST_PC));
    waitDrain("stream");
    checkOutput("bus idle", if22id_bus, 65'd0);

    // Full FIFO held by a decode stall.
    stall = 6'b000010;
    pushPcs(32'h8000_0020, 4, 1'b1);
    repeat (4) stepCycle();
    for (int k = 0; k < 3; k++) begin
      #7;
      checkOutput("stall req", {64'd0, imem_req}, 65'd0);
      checkOutput("stall hold", if22id_bus, busOf(32'h8000_0020));
      stepCycle();
    end
    stall = 6'd0;
    waitDrain("stall");

    // Branch with two requests in flight.
    lat = 4;
    pushPcs(32'h8000_0030, 2, 1'b0);
    stepCycle();
    stepCycle();
    br_bus = {1'b1, 32'h8000_0100};
    #7;
    checkOutput("branch req", {64'd0, imem_req}, 65'd0);
    stepCycle();
    br_bus = 33'd0;
    pushPcs(32'h8000_0100, 3, 1'b1);
    #7;
    checkOutput("branch addr", {33'd0, imem_addr}, {33'd0, 32'h8000_0100});
    waitDrain("branch");
    lat = 1;

    // Branch ignored under stall, then flush beats branch and clears the FIFO.
    stall = 6'b000010;
    pushPcs(32'h8000_010C, 2, 1'b0);
    repeat (4) stepCycle();
    br_bus = {1'b1, 32'h8000_0300};
    stepCycle();
    br_bus = 33'd0;
    #7;
    checkOutput("stalled br bus", if22id_bus, busOf(32'h8000_010C));
    checkOutput("stalled br pc", {33'd0, imem_addr}, {33'd0, 32'h8000_0114});
    stepCycle();
    flush = 1'b1; flush_pc = 32'h8000_0200; br_bus = {1'b1, 32'h8000_0300}; stall = 6'd0;
    #7;
    checkOutput("flush req", {64'd0, imem_req}, 65'd0);
    stepCycle();
    flush = 1'b0; br_bus = 33'd0;
    pushPcs(32'h8000_0200, 2, 1'b1);
    #7;
    checkOutput("flush cleared", if22id_bus, 65'd0);
    checkOutput("flush addr", {33'd0, imem_addr}, {33'd0, 32'h8000_0200});
    waitDrain("flush");

    // Reset with a full FIFO.
    stall = 6'b000010;
    pushPcs(32'h8000_0208, 2, 1'b0);
    repeat (4) stepCycle();
    rst = 1'b1;
    #7;
    checkOutput("rst req", {64'd0, imem_req}, 65'd0);
    stepCycle(); #7;
    checkOutput("rst bus", if22id_bus, 65'd0);
    checkOutput("rst req2", {64'd0, imem_req}, 65'd0);
    stepCycle();
    rst = 1'b0; stall = 6'd0;
    pushPcs(RST_PC, 2, 1'b1);
    #7;
    checkOutput("rst pc", {33'd0, imem_addr}, {33'd0, RST_PC});

    // Grant withheld: address must stay put.
    repeat (3) stepCycle();
    for (int k = 0; k < 4; k++) begin
      #7;
      checkOutput("nognt req", {64'd0, imem_req}, 65'd1);
      checkOutput("nognt addr", {33'd0, imem_addr}, {33'd0, 32'h8000_0008});
      stepCycle();
    end
    pushPcs(32'h8000_0008, 2, 1'b1);
    waitDrain("nognt");

    checkOutput("leftover addr", 65'(expAddr.size()), 65'd0);
    checkOutput("leftover bus", 65'(expBus.size()), 65'd0);
  endtask

  initial begin
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
